mem_access_unit: RTL and testbench

Memory-stage load/store unit of the MIPS pipeline, placed between the EX/MEM latch and the word-addressed data memory. It converts byte addresses to word addresses and performs byte/halfword loads with sign or zero extension. Sub-word stores are done as a two-cycle read-modify-write, with a pipeline stall, because the data memory only writes whole words. Results are registered into the MEM/WB latch fields it drives.

---
 rtl/mem_access_unit.sv | 219 +++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit
// Memory-stage load/store unit placed between the EX/MEM latch and a
// word-addressed data memory. It turns byte addresses into word addresses,
// extracts and extends byte/halfword loads, and performs sub-word stores as a
// two-cycle read-modify-write with a one-cycle stall. Results are registered
// into the MEM/WB fields it drives.
//
// Optional feature macro: MEM_ACCESS_ALIGN_CHECK_EN
//   defined   -> misaligned half/word accesses raise o_wb_exception, issue no
//                strobes and never stall.
//   undefined -> o_wb_exception stays 0 and the offending low address bits
//                are ignored (half uses address[1] only, word ignores [1:0]).

module mem_access_unit #(
    parameter int NB_DATA = 32,
    parameter int NB_REG  = 5
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_valid,
    input  logic               i_mem_read,
    input  logic               i_mem_write,
    input  logic [1:0]         i_size,
    input  logic               i_unsigned,
    input  logic [NB_DATA-1:0] i_address,
    input  logic [NB_DATA-1:0] i_store_data,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic               i_mem_to_reg,
    input  logic               i_reg_write,
    input  logic [NB_REG-1:0]  i_rd_addr,
    input  logic [NB_DATA-1:0] i_mem_read_data,
    output logic [NB_DATA-1:0] o_mem_address,
    output logic [NB_DATA-1:0] o_mem_write_data,
    output logic               o_mem_read_enable,
    output logic               o_mem_write_enable,
    output logic               o_mem_valid,
    output logic               o_stall,
    output logic               o_wb_valid,
    output logic               o_wb_reg_write,
    output logic               o_wb_exception,
    output logic [NB_DATA-1:0] o_wb_data,
    output logic [NB_REG-1:0]  o_wb_rd_addr
);

    localparam logic [0:0] ST_IDLE      = 1'b0;
    localparam logic [0:0] ST_RMW_WRITE = 1'b1;

    logic [0:0]         state_q,      state_d;
    logic [NB_DATA-1:0] rmwAddr_q,    rmwAddr_d;
    logic [NB_DATA-1:0] rmwData_q,    rmwData_d;
    logic [NB_DATA-1:0] rmwAlu_q,     rmwAlu_d;
    logic [NB_REG-1:0]  rmwRd_q,      rmwRd_d;
    logic               wbValid_q,    wbValid_d;
    logic               wbRegWrite_q, wbRegWrite_d;
    logic               wbExc_q,      wbExc_d;
    logic [NB_DATA-1:0] wbData_q,     wbData_d;
    logic [NB_REG-1:0]  wbRd_q,       wbRd_d;

    logic               sizeByte;
    logic               sizeHalf;
    logic               sizeWord;
    logic [1:0]         laneOffset;
    logic               misaligned;
    logic               accessReq;
    logic               doStore;
    logic               doLoad;
    logic               subWordStore;
    logic               excHit;
    logic [NB_DATA-1:0] wordAddr;
    logic [NB_DATA-1:0] mergedWord;
    logic [7:0]         loadByte;
    logic [15:0]        loadHalf;
    logic [NB_DATA-1:0] loadValue;

    // Decode the access: size, effective lane offset, alignment and request kind
    always_comb begin
        sizeByte = (i_size == 2'b00);
        sizeHalf = (i_size == 2'b01);
        sizeWord = i_size[1];
        if (sizeByte) begin
            laneOffset = i_address[1:0];
        end else if (sizeHalf) begin
            laneOffset = {i_address[1], 1'b0};
        end else begin
            laneOffset = 2'b00;
        end
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
        misaligned = (sizeHalf & i_address[0]) | (sizeWord & (|i_address[1:0]));
`else
        misaligned = 1'b0;
`endif
        accessReq    = i_valid & (i_mem_read | i_mem_write);
        excHit       = accessReq & misaligned;
        doStore      = i_valid & i_mem_write & ~misaligned;
        doLoad       = i_valid & i_mem_read & ~i_mem_write & ~misaligned;
        subWordStore = doStore & ~sizeWord;
        wordAddr     = {2'b00, i_address[NB_DATA-1:2]};
    end

    // Merge the store lane(s) into the word currently held in memory
    always_comb begin
        mergedWord = i_mem_read_data;
        if (sizeByte) begin
            mergedWord[{laneOffset, 3'b000} +: 8] = i_store_data[7:0];
        end else if (sizeHalf) begin
            mergedWord[{laneOffset[1], 4'b0000} +: 16] = i_store_data[15:0];
        end
    end

    // Extract the loaded byte/half/word and sign- or zero-extend it
    always_comb begin
        loadByte = i_mem_read_data[{laneOffset, 3'b000} +: 8];
        loadHalf = i_mem_read_data[{laneOffset[1], 4'b0000} +: 16];
        if (sizeByte) begin
            loadValue = {{(NB_DATA-8){loadByte[7] & ~i_unsigned}}, loadByte};
        end else if (sizeHalf) begin
            loadValue = {{(NB_DATA-16){loadHalf[15] & ~i_unsigned}}, loadHalf};
        end else begin
            loadValue = i_mem_read_data;
        end
    end

    // Drive memory strobes and stall; everything is quiet while reset is high
    always_comb begin
        o_mem_address      = wordAddr;
        o_mem_write_data   = i_store_data;
        o_mem_read_enable  = 1'b0;
        o_mem_write_enable = 1'b0;
        o_stall            = 1'b0;
        if (!i_reset) begin
            if (state_q == ST_RMW_WRITE) begin
                o_mem_address      = rmwAddr_q;
                o_mem_write_data   = rmwData_q;
                o_mem_write_enable = 1'b1;
            end else if (subWordStore) begin
                o_mem_read_enable = 1'b1;
                o_stall           = 1'b1;
            end else if (doStore) begin
                o_mem_write_enable = 1'b1;
            end else if (doLoad) begin
                o_mem_read_enable = 1'b1;
            end
        end
        o_mem_valid = o_mem_read_enable | o_mem_write_enable;
    end

    // Next-state logic for the RMW sequencer and the MEM/WB fields
    always_comb begin
        state_d      = state_q;
        rmwAddr_d    = rmwAddr_q;
        rmwData_d    = rmwData_q;
        rmwAlu_d     = rmwAlu_q;
        rmwRd_d      = rmwRd_q;
        wbValid_d    = wbValid_q;
        wbRegWrite_d = wbRegWrite_q;
        wbExc_d      = wbExc_q;
        wbData_d     = wbData_q;
        wbRd_d       = wbRd_q;
        if (state_q == ST_RMW_WRITE) begin
            // The upstream latch still shows the same store; finish it from
            // the captured copy and retire it without a register write.
            state_d      = ST_IDLE;
            wbValid_d    = 1'b1;
            wbRegWrite_d = 1'b0;
            wbExc_d      = 1'b0;
            wbData_d     = rmwAlu_q;
            wbRd_d       = rmwRd_q;
        end else if (subWordStore) begin
            state_d      = ST_RMW_WRITE;
            rmwAddr_d    = wordAddr;
            rmwData_d    = mergedWord;
            rmwAlu_d     = i_alu_result;
            rmwRd_d      = i_rd_addr;
            wbValid_d    = 1'b0;
            wbRegWrite_d = 1'b0;
            wbExc_d      = 1'b0;
        end else begin
            wbValid_d    = i_valid;
            wbRegWrite_d = i_valid & i_reg_write & ~excHit;
            wbExc_d      = excHit;
            wbData_d     = i_mem_to_reg ? loadValue : i_alu_result;
            wbRd_d       = i_rd_addr;
        end
    end

    // State and MEM/WB registers with synchronous reset
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q      <= ST_IDLE;
            rmwAddr_q    <= '0;
            rmwData_q    <= '0;
            rmwAlu_q     <= '0;
            rmwRd_q      <= '0;
            wbValid_q    <= 1'b0;
            wbRegWrite_q <= 1'b0;
            wbExc_q      <= 1'b0;
            wbData_q     <= '0;
            wbRd_q       <= '0;
        end else begin
            state_q      <= state_d;
            rmwAddr_q    <= rmwAddr_d;
            rmwData_q    <= rmwData_d;
            rmwAlu_q     <= rmwAlu_d;
            rmwRd_q      <= rmwRd_d;
            wbValid_q    <= wbValid_d;
            wbRegWrite_q <= wbRegWrite_d;
            wbExc_q      <= wbExc_d;
            wbData_q     <= wbData_d;
            wbRd_q       <= wbRd_d;
        end
    end

    assign o_wb_valid     = wbValid_q;
    assign o_wb_reg_write = wbRegWrite_q;
    assign o_wb_exception = wbExc_q;
    assign o_wb_data      = wbData_q;
    assign o_wb_rd_addr   = wbRd_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit with a small word-addressed memory
// model that commits writes on the falling clock edge.

module tb_mem_access_unit;

    logic        i_clock;
    logic        i_reset;
    logic        i_valid;
    logic        i_mem_read;
    logic        i_mem_write;
    logic [1:0]  i_size;
    logic        i_unsigned;
    logic [31:0] i_address;
    logic [31:0] i_store_data;
    logic [31:0] i_alu_result;
    logic        i_mem_to_reg;
    logic        i_reg_write;
    logic [4:0]  i_rd_addr;
    logic [31:0] i_mem_read_data;
    logic [31:0] o_mem_address;
    logic [31:0] o_mem_write_data;
    logic        o_mem_read_enable;
    logic        o_mem_write_enable;
    logic        o_mem_valid;
    logic        o_stall;
    logic        o_wb_valid;
    logic        o_wb_reg_write;
    logic        o_wb_exception;
    logic [31:0] o_wb_data;
    logic [4:0]  o_wb_rd_addr;

    logic [31:0] mem [16];
    logic        preloadReq;
    logic [3:0]  preloadAddr;
    logic [31:0] preloadData;

    int assertCount;
    int failCount;

    mem_access_unit #(.NB_DATA(32), .NB_REG(5)) dut (
        .i_clock           (i_clock),
        .i_reset           (i_reset),
        .i_valid           (i_valid),
        .i_mem_read        (i_mem_read),
        .i_mem_write       (i_mem_write),
        .i_size            (i_size),
        .i_unsigned        (i_unsigned),
        .i_address         (i_address),
        .i_store_data      (i_store_data),
        .i_alu_result      (i_alu_result),
        .i_mem_to_reg      (i_mem_to_reg),
        .i_reg_write       (i_reg_write),
        .i_rd_addr         (i_rd_addr),
        .i_mem_read_data   (i_mem_read_data),
        .o_mem_address     (o_mem_address),
        .o_mem_write_data  (o_mem_write_data),
        .o_mem_read_enable (o_mem_read_enable),
        .o_mem_write_enable(o_mem_write_enable),
        .o_mem_valid       (o_mem_valid),
        .o_stall           (o_stall),
        .o_wb_valid        (o_wb_valid),
        .o_wb_reg_write    (o_wb_reg_write),
        .o_wb_exception    (o_wb_exception),
        .o_wb_data         (o_wb_data),
        .o_wb_rd_addr      (o_wb_rd_addr)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        i_clock = 1'b0;
        forever #5 i_clock = ~i_clock;
    end

    assign i_mem_read_data = mem[o_mem_address[3:0]];

    // Memory model: single writer process, commits on the falling edge
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[4] = 32'h8899AABB;
        forever begin
            @(negedge i_clock);
            if (o_mem_write_enable) mem[o_mem_address[3:0]] = o_mem_write_data;
            if (preloadReq) mem[preloadAddr] = preloadData;
        end
    end

    task automatic applyStimulus(input logic valid, input logic rd, input logic wr,
                                 input logic [1:0] size, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] sdata,
                                 input logic [31:0] alu, input logic m2r,
                                 input logic regw, input logic [4:0] rdAddr);
        i_valid      = valid;
        i_mem_read   = rd;
        i_mem_write  = wr;
        i_size       = size;
        i_unsigned   = uns;
        i_address    = addr;
        i_store_data = sdata;
        i_alu_result = alu;
        i_mem_to_reg = m2r;
        i_reg_write  = regw;
        i_rd_addr    = rdAddr;
    endtask

    task automatic idleInputs();
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic preloadWord4(input logic [31:0] value);
        preloadReq  = 1'b1;
        preloadAddr = 4'd4;
        preloadData = value;
        @(negedge i_clock);
        #1;
        preloadReq = 1'b0;
        @(posedge i_clock);
        #1;
    endtask

    // Runs one load and checks the registered result one edge later
    task automatic runLoad(input string name, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [4:0] rdAddr,
                           input logic [31:0] expData);
        applyStimulus(1'b1, 1'b1, 1'b0, size, uns, addr, 32'h0, 32'hCAFE0000, 1'b1, 1'b1, rdAddr);
        #1;
        assertCount++;
        if (o_mem_read_enable !== 1'b1 || o_stall !== 1'b0) begin
            $display("FAIL %s strobe: read_en=%b stall=%b expected 1/0", name, o_mem_read_enable, o_stall);
            failCount++;
        end
        @(posedge i_clock);
        #1;
        assertCount++;
        if (o_wb_data !== expData || o_wb_rd_addr !== rdAddr || o_wb_reg_write !== 1'b1) begin
            $display("FAIL %s data: got %h rd=%0d regw=%b expected %h rd=%0d regw=1",
                     name, o_wb_data, o_wb_rd_addr, o_wb_reg_write, expData, rdAddr);
            failCount++;
        end
    endtask

    task automatic test_reset();
        i_reset    = 1'b1;
        preloadReq = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 1'b1, 5'd3);
        @(posedge i_clock);
        @(posedge i_clock);
        #1;
        assertCount++;
        if (o_mem_read_enable !== 1'b0 || o_mem_write_enable !== 1'b0 || o_stall !== 1'b0 || o_mem_valid !== 1'b0) begin
            $display("FAIL reset_strobes: re=%b we=%b stall=%b valid=%b expected all 0",
                     o_mem_read_enable, o_mem_write_enable, o_stall, o_mem_valid);
            failCount++;
        end
        assertCount++;
        if (o_wb_valid !== 1'b0 || o_wb_reg_write !== 1'b0 || o_wb_exception !== 1'b0 ||
            o_wb_data !== 32'h0 || o_wb_rd_addr !== 5'd0) begin
            $display("FAIL reset_wb: valid=%b regw=%b exc=%b data=%h rd=%0d expected all 0",
                     o_wb_valid, o_wb_reg_write, o_wb_exception, o_wb_data, o_wb_rd_addr);
            failCount++;
        end
        i_reset = 1'b0;
        idleInputs();
        @(posedge i_clock);
        #1;
    endtask

    task automatic test_load();
        applyStimulus(1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 1'b1, 5'd7);
        #1;
        assertCount++;
        if (o_mem_address !== 32'd4 || o_mem_valid !== 1'b1 || o_mem_write_enable !== 1'b0) begin
            $display("FAIL lw_address: addr=%h valid=%b we=%b expected 4/1/0",
                     o_mem_address, o_mem_valid, o_mem_write_enable);
            failCount++;
        end
        @(posedge i_clock);
        #1;
        assertCount++;
        if (o_wb_data !== 32'h8899AABB || o_wb_reg_write !== 1'b1 || o_wb_valid !== 1'b1) begin
            $display("FAIL lw_data: got %h regw=%b valid=%b expected 8899aabb/1/1",
                     o_wb_data, o_wb_reg_write, o_wb_valid);
            failCount++;
        end
        runLoad("lb_13",  2'b00, 1'b0, 32'h13, 5'd8,  32'hFFFFFF88);
        runLoad("lbu_13", 2'b00, 1'b1, 32'h13, 5'd9,  32'h00000088);
        runLoad("lb_10",  2'b00, 1'b0, 32'h10, 5'd10, 32'hFFFFFFBB);
        runLoad("lh_12",  2'b01, 1'b0, 32'h12, 5'd11, 32'hFFFF8899);
        runLoad("lhu_10", 2'b01, 1'b1, 32'h10, 5'd12, 32'h0000AABB);
    endtask

    task automatic test_subword_store();
        applyStimulus(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h11, 32'h00000055, 32'h11, 1'b0, 1'b0, 5'd0);
        #1;
        assertCount++;
        if (o_stall !== 1'b1 || o_mem_read_enable !== 1'b1 || o_mem_write_enable !== 1'b0) begin
            $display("FAIL sb_cycle1: stall=%b re=%b we=%b expected 1/1/0", o_stall, o_mem_read_enable, o_mem_write_enable);
            failCount++;
        end
        @(posedge i_clock);
        #1;
        assertCount++;
        if (o_stall !== 1'b0 || o_mem_write_enable !== 1'b1 || o_mem_read_enable !== 1'b0 ||
            o_mem_address !== 32'd4 || o_mem_write_data !== 32'h889955BB) begin
            $display("FAIL sb_cycle2: stall=%b we=%b re=%b addr=%h wdata=%h expected 0/1/0/4/889955bb",
                     o_stall, o_mem_write_enable, o_mem_read_enable, o_mem_address, o_mem_write_data);
            failCount++;
        end
        assertCount++;
        if (o_wb_valid !== 1'b0) begin
            $display("FAIL sb_wb_hold: wb_valid=%b expected 0", o_wb_valid);
            failCount++;
        end
        @(posedge i_clock);
        #1;
        assertCount++;
        if (o_wb_valid !== 1'b1 || o_wb_reg_write !== 1'b0 || mem[4] !== 32'h889955BB) begin
            $display("FAIL sb_retire: wb_valid=%b regw=%b mem4=%h expected 1/0/889955bb",
                     o_wb_valid, o_wb_reg_write, mem[4]);
            failCount++;
        end
        runLoad("lw_after_sb", 2'b11, 1'b0, 32'h10, 5'd13, 32'h889955BB);
    endtask

    task automatic test_half_store();
        idleInputs();
        preloadWord4(32'h8899AABB);
        applyStimulus(1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 32'h12, 32'h00001234, 32'h12, 1'b0, 1'b0, 5'd0);
        #1;
        assertCount++;
        if (o_stall !== 1'b1) begin
            $display("FAIL sh_stall: stall=%b expected 1", o_stall);
            failCount++;
        end
        @(posedge i_clock);
        #1;
        assertCount++;
        if (o_mem_write_enable !== 1'b1 || o_mem_write_data !== 32'h1234AABB || o_stall !== 1'b0) begin
            $display("FAIL sh_write: we=%b wdata=%h stall=%b expected 1/1234aabb/0",
                     o_mem_write_enable, o_mem_write_data, o_stall);
            failCount++;
        end
        @(posedge i_clock);
        #1;
        runLoad("lw_after_sh", 2'b11, 1'b0, 32'h10, 5'd14, 32'h1234AABB);
    endtask

    task automatic test_word_store();
        applyStimulus(1'b1, 1'b0, 1'b1, 2'b11, 1'b0, 32'h10, 32'hDEADBEEF, 32'h10, 1'b0, 1'b0, 5'd0);
        #1;
        assertCount++;
        if (o_stall !== 1'b0 || o_mem_write_enable !== 1'b1 || o_mem_read_enable !== 1'b0 ||
            o_mem_write_data !== 32'hDEADBEEF || o_mem_address !== 32'd4) begin
            $display("FAIL sw_cycle: stall=%b we=%b re=%b wdata=%h addr=%h expected 0/1/0/deadbeef/4",
                     o_stall, o_mem_write_enable, o_mem_read_enable, o_mem_write_data, o_mem_address);
            failCount++;
        end
        @(posedge i_clock);
        #1;
        assertCount++;
        if (mem[4] !== 32'hDEADBEEF || o_wb_valid !== 1'b1 || o_wb_reg_write !== 1'b0) begin
            $display("FAIL sw_commit: mem4=%h valid=%b regw=%b expected deadbeef/1/0", mem[4], o_wb_valid, o_wb_reg_write);
            failCount++;
        end
        runLoad("lw_after_sw", 2'b11, 1'b0, 32'h10, 5'd15, 32'hDEADBEEF);
    endtask

    task automatic test_misaligned();
        idleInputs();
        preloadWord4(32'h8899AABB);
        applyStimulus(1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 32'h12, 32'h0, 32'h0, 1'b1, 1'b1, 5'd16);
        #1;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
        assertCount++;
        if (o_mem_valid !== 1'b0 || o_mem_read_enable !== 1'b0 || o_mem_write_enable !== 1'b0 || o_stall !== 1'b0) begin
            $display("FAIL misaligned_strobes: valid=%b re=%b we=%b stall=%b expected all 0",
                     o_mem_valid, o_mem_read_enable, o_mem_write_enable, o_stall);
            failCount++;
        end
        @(posedge i_clock);
        #1;
        assertCount++;
        if (o_wb_exception !== 1'b1 || o_wb_valid !== 1'b1 || o_wb_reg_write !== 1'b0 || mem[4] !== 32'h8899AABB) begin
            $display("FAIL misaligned_wb: exc=%b valid=%b regw=%b mem4=%h expected 1/1/0/8899aabb",
                     o_wb_exception, o_wb_valid, o_wb_reg_write, mem[4]);
            failCount++;
        end
`else
        assertCount++;
        if (o_mem_read_enable !== 1'b1 || o_mem_address !== 32'd4) begin
            $display("FAIL misaligned_strobes: re=%b addr=%h expected 1/4", o_mem_read_enable, o_mem_address);
            failCount++;
        end
        @(posedge i_clock);
        #1;
        assertCount++;
        if (o_wb_data !== 32'h8899AABB || o_wb_exception !== 1'b0 || o_wb_reg_write !== 1'b1) begin
            $display("FAIL misaligned_wb: data=%h exc=%b regw=%b expected 8899aabb/0/1",
                     o_wb_data, o_wb_exception, o_wb_reg_write);
            failCount++;
        end
`endif
    endtask

    task automatic test_read_write_conflict();
        applyStimulus(1'b1, 1'b1, 1'b1, 2'b11, 1'b0, 32'h14, 32'h01020304, 32'h14, 1'b0, 1'b0, 5'd0);
        #1;
        assertCount++;
        if (o_mem_read_enable !== 1'b0 || o_mem_write_enable !== 1'b1 || o_mem_address !== 32'd5) begin
            $display("FAIL rw_conflict: re=%b we=%b addr=%h expected 0/1/5", o_mem_read_enable, o_mem_write_enable, o_mem_address);
            failCount++;
        end
        @(posedge i_clock);
        #1;
        assertCount++;
        if (mem[5] !== 32'h01020304) begin
            $display("FAIL rw_conflict_mem: mem5=%h expected 01020304", mem[5]);
            failCount++;
        end
    endtask

    task automatic test_non_memory();
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 32'h12345678, 32'h0, 32'h12345678, 1'b0, 1'b1, 5'd21);
        #1;
        assertCount++;
        if (o_mem_valid !== 1'b0 || o_stall !== 1'b0) begin
            $display("FAIL alu_strobes: valid=%b stall=%b expected 0/0", o_mem_valid, o_stall);
            failCount++;
        end
        @(posedge i_clock);
        #1;
        assertCount++;
        if (o_wb_data !== 32'h12345678 || o_wb_rd_addr !== 5'd21 || o_wb_reg_write !== 1'b1 || o_wb_valid !== 1'b1) begin
            $display("FAIL alu_wb: data=%h rd=%0d regw=%b valid=%b expected 12345678/21/1/1",
                     o_wb_data, o_wb_rd_addr, o_wb_reg_write, o_wb_valid);
            failCount++;
        end
    endtask

    task automatic test_invalid();
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 1'b1, 5'd22);
        #1;
        assertCount++;
        if (o_mem_valid !== 1'b0 || o_mem_read_enable !== 1'b0) begin
            $display("FAIL invalid_strobes: valid=%b re=%b expected 0/0", o_mem_valid, o_mem_read_enable);
            failCount++;
        end
        @(posedge i_clock);
        #1;
        assertCount++;
        if (o_wb_valid !== 1'b0 || o_wb_reg_write !== 1'b0) begin
            $display("FAIL invalid_wb: valid=%b regw=%b expected 0/0", o_wb_valid, o_wb_reg_write);
            failCount++;
        end
    endtask

    task automatic test_reset_mid_rmw();
        idleInputs();
        preloadWord4(32'h8899AABB);
        applyStimulus(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h11, 32'h00000055, 32'h11, 1'b0, 1'b0, 5'd0);
        @(posedge i_clock);
        #1;
        i_reset = 1'b1;
        #1;
        assertCount++;
        if (o_mem_write_enable !== 1'b0 || o_stall !== 1'b0) begin
            $display("FAIL rmw_reset_strobe: we=%b stall=%b expected 0/0", o_mem_write_enable, o_stall);
            failCount++;
        end
        @(posedge i_clock);
        #1;
        assertCount++;
        if (mem[4] !== 32'h8899AABB || o_wb_valid !== 1'b0 || o_wb_reg_write !== 1'b0 ||
            o_wb_exception !== 1'b0 || o_wb_data !== 32'h0 || o_wb_rd_addr !== 5'd0) begin
            $display("FAIL rmw_reset_state: mem4=%h valid=%b regw=%b exc=%b data=%h rd=%0d expected 8899aabb/0/0/0/0/0",
                     mem[4], o_wb_valid, o_wb_reg_write, o_wb_exception, o_wb_data, o_wb_rd_addr);
            failCount++;
        end
        i_reset = 1'b0;
        runLoad("lw_after_rmw_reset", 2'b11, 1'b0, 32'h10, 5'd23, 32'h8899AABB);
        assertCount++;
        if (o_mem_write_enable !== 1'b0) begin
            $display("FAIL rmw_reset_idle: we=%b expected 0", o_mem_write_enable);
            failCount++;
        end
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        preloadReq  = 1'b0;
        preloadAddr = 4'd0;
        preloadData = 32'h0;
        test_reset();
        test_load();
        test_subword_store();
        test_half_store();
        test_word_store();
        test_misaligned();
        test_read_write_conflict();
        test_non_memory();
        test_invalid();
        test_reset_mid_rmw();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
